// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM state
// codes and the register-to-register datapath mux selects.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_STORE = 3'b000,
    OP_LOAD  = 3'b001,
    OP_RMOV  = 3'b010,
    OP_ALU   = 3'b011,
    OP_KLOAD = 3'b100
  } opcode_e;

  // FSM state codes, kept as plain constants so older tools and scripts
  // that grep the encoding keep working.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RAM_WR = 3'd1;
  localparam logic [2:0] ST_RAM_RD = 3'd2;
  localparam logic [2:0] ST_ROM_RD = 3'd3;
  localparam logic [2:0] ST_GPR_WR = 3'd4;
  localparam logic [2:0] ST_ALU    = 3'd5;
  localparam logic [2:0] ST_ILL    = 3'd6;

  // Datapath mux selects.
  localparam logic [1:0] SEL_RAM2ROM = 2'b00;
  localparam logic [1:0] SEL_ROM2GPR = 2'b01;
  localparam logic [1:0] SEL_RAM2GPR = 2'b10;
  localparam logic [1:0] SEL_ALU2GPR = 2'b11;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer. Takes one instruction per valid/ready
// handshake and walks the RAM / ROM / GPR / ALU micro-phases it needs.
//
// Handshake: an instruction is consumed on a rising edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE (and only
// once the block is out of reset); a source holding instr_valid while the
// sequencer is busy simply waits, keeping instr stable until consumed.
//
// Strobes are decoded from the state register. Address/code/select fields
// are registers loaded on entry to the state that uses them, so they hold
// their last value when idle and never see instr combinationally.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int RAM_AW   = 2,
  parameter int GPR_AW   = 3,
  parameter int ROM_WAIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [3+GPR_AW+RAM_AW-1:0] instr,
  output logic                       instr_ready,
  output logic                       ram_rd_en,
  output logic                       ram_wr_en,
  output logic [RAM_AW-1:0]          ram_addr,
  output logic                       rom_rd_en,
  output logic                       rom_kernel_en,
  output logic                       rom_rst_n,
  output logic                       gpr_rd_en,
  output logic                       gpr_wr_en,
  output logic                       gpr_alu_en,
  output logic [GPR_AW-1:0]          gpr_addr,
  output logic [1:0]                 sel_r2r,
  output logic                       alu_en,
  output logic [GPR_AW-1:0]          alu_code,
  output logic                       done,
  output logic                       illegal,
  output logic [2:0]                 dbg_state
);

  localparam int INSTR_W = 3 + GPR_AW + RAM_AW;
  localparam int CNT_W   = (ROM_WAIT < 2) ? 1 : $clog2(ROM_WAIT + 1);

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               alive_q;
  logic               accept;

  logic [2:0]         op_d;
  logic [2:0]         op_q;
  logic [RAM_AW-1:0]  ram_fld_d;
  logic [GPR_AW-1:0]  gpr_fld_d;

  assign accept    = instr_valid && instr_ready;
  // Instruction the next state is working on: the incoming word on an
  // accept edge, the captured one otherwise.
  assign instr_d   = accept ? instr : instr_q;
  assign op_d      = instr_d[INSTR_W-1 -: 3];
  assign op_q      = instr_q[INSTR_W-1 -: 3];
  assign ram_fld_d = instr_d[RAM_AW-1:0];
  assign gpr_fld_d = instr_d[RAM_AW +: GPR_AW];

  // Next-state decode of the micro-phase sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_d)
            OP_STORE: state_d = ST_RAM_WR;
            OP_LOAD,
            OP_KLOAD: state_d = ST_RAM_RD;
            OP_RMOV:  state_d = (ram_fld_d == '0) ? ST_ILL : ST_RAM_RD;
            OP_ALU:   state_d = ST_ALU;
            default:  state_d = ST_ILL;
          endcase
        end
      end
      ST_RAM_RD: state_d = (op_q == OP_RMOV) ? ST_GPR_WR : ST_ROM_RD;
      ST_ROM_RD: if (cnt_q == CNT_W'(1)) state_d = ST_GPR_WR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, captured instruction, ROM wait counter and reset-release flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) instr_q <= instr;
      if (state_d == ST_ROM_RD && state_q != ST_ROM_RD) begin
        cnt_q <= CNT_W'(ROM_WAIT);
      end else if (state_q == ST_ROM_RD) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Held output fields, loaded as the state that uses them is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      gpr_addr <= '0;
      alu_code <= '0;
      sel_r2r  <= '0;
    end else if (state_d != state_q) begin
      case (state_d)
        ST_RAM_WR: ram_addr <= ram_fld_d;
        ST_RAM_RD: begin
          ram_addr <= ram_fld_d;
          if (op_d != OP_RMOV) sel_r2r <= SEL_RAM2ROM;
        end
        ST_GPR_WR: begin
          gpr_addr <= gpr_fld_d;
          sel_r2r  <= (op_d == OP_RMOV) ? SEL_RAM2GPR : SEL_ROM2GPR;
        end
        ST_ALU: begin
          gpr_addr <= gpr_fld_d;
          alu_code <= gpr_fld_d;
          sel_r2r  <= SEL_ALU2GPR;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready   = alive_q && (state_q == ST_IDLE);
  assign rom_rst_n     = alive_q;
  assign ram_wr_en     = (state_q == ST_RAM_WR);
  assign ram_rd_en     = (state_q == ST_RAM_RD);
  assign rom_rd_en     = (state_q == ST_ROM_RD);
  assign rom_kernel_en = (state_q == ST_ROM_RD) && (op_q == OP_KLOAD);
  assign gpr_rd_en     = 1'b0;
  assign gpr_wr_en     = (state_q == ST_GPR_WR);
  assign gpr_alu_en    = (state_q == ST_ALU);
  assign alu_en        = (state_q == ST_ALU);
  assign done          = (state_q == ST_RAM_WR) || (state_q == ST_GPR_WR) ||
                         (state_q == ST_ALU);
  assign illegal       = (state_q == ST_ILL);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer (RAM_AW=2, GPR_AW=3, ROM_WAIT=3): directed
// instructions followed by random ones, each expanded by a phase-level
// model into the expected output word for every cycle.
module tb_instr_sequencer;

  localparam int RAM_AW   = 2;
  localparam int GPR_AW   = 3;
  localparam int ROM_WAIT = 3;
  localparam int VW       = 22;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [7:0]       instr = '0;
  logic             instr_ready, ram_rd_en, ram_wr_en, rom_rd_en, rom_kernel_en;
  logic             rom_rst_n, gpr_rd_en, gpr_wr_en, gpr_alu_en, alu_en, done, illegal;
  logic [1:0]       ram_addr, sel_r2r;
  logic [2:0]       gpr_addr, alu_code, dbg_state;

  int n_chk = 0;
  int n_err = 0;

  // Model's view of the held fields.
  logic [1:0] m_ra, m_sel;
  logic [2:0] m_ga, m_ac;

  logic [VW-1:0] exp_q[$];

  instr_sequencer #(.RAM_AW(RAM_AW), .GPR_AW(GPR_AW), .ROM_WAIT(ROM_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .rom_rd_en(rom_rd_en), .rom_kernel_en(rom_kernel_en),
    .rom_rst_n(rom_rst_n), .gpr_rd_en(gpr_rd_en), .gpr_wr_en(gpr_wr_en),
    .gpr_alu_en(gpr_alu_en), .gpr_addr(gpr_addr), .sel_r2r(sel_r2r),
    .alu_en(alu_en), .alu_code(alu_code), .done(done), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {instr_ready, ram_rd_en, ram_wr_en, ram_addr, rom_rd_en, rom_kernel_en,
            rom_rst_n, gpr_rd_en, gpr_wr_en, gpr_alu_en, gpr_addr, sel_r2r,
            alu_en, alu_code, done, illegal};
  endfunction

  function automatic logic [VW-1:0] mk(input logic rdy, input logic rd, input logic wr,
                                       input logic rom, input logic kern, input logic gwr,
                                       input logic galu, input logic alu, input logic dn,
                                       input logic ill);
    return {rdy, rd, wr, m_ra, rom, kern, 1'b1, 1'b0, gwr, galu, m_ga, m_sel,
            alu, m_ac, dn, ill};
  endfunction

  // Expand one instruction into its per-cycle expected outputs, then idle.
  task automatic model_push(input logic [7:0] ins);
    logic [2:0] op;
    logic [2:0] ga;
    logic [1:0] ra;
    op = ins[7:5];
    ga = ins[4:2];
    ra = ins[1:0];
    case (op)
      3'b000: begin
        m_ra = ra;
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
      end
      3'b001, 3'b100: begin
        m_ra = ra;
        m_sel = 2'b00;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < ROM_WAIT; i++)
          exp_q.push_back(mk(0, 0, 0, 1, op == 3'b100, 0, 0, 0, 0, 0));
        m_ga = ga;
        m_sel = 2'b01;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
      end
      3'b010: begin
        if (ra == 2'd0) begin
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
          m_ra = ra;
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
          m_ga = ga;
          m_sel = 2'b10;
          exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        end
      end
      3'b011: begin
        m_ga = ga;
        m_ac = ga;
        m_sel = 2'b11;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      end
      default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Driver: called #1 after an edge in an idle cycle. Checks up to
  // max_cyc cycles of the sequence (including the trailing idle cycle).
  task automatic issue(input logic [7:0] ins, input int max_cyc);
    string tag;
    int n;
    logic [VW-1:0] e;
    tag = $sformatf("op%0d_%02h", ins[7:5], ins);
    check_eq({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    model_push(ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      e = exp_q.pop_front();
      check_eq(tag, {{(32-VW){1'b0}}, obs_vec()}, {{(32-VW){1'b0}}, e});
      n++;
      // Keep offering while busy; it must not be consumed until IDLE.
      instr_valid = (exp_q.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (exp_q.size() > 0 && n < max_cyc) begin
        @(posedge clk); #1;
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check_eq("idle", {{(32-VW){1'b0}}, obs_vec()},
               {{(32-VW){1'b0}}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    end
  endtask

  task automatic model_reset();
    m_ra = '0;
    m_ga = '0;
    m_ac = '0;
    m_sel = '0;
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] ins;
    model_reset();
    // Reset block
    #3;
    check_eq("reset_outputs", {{(32-VW){1'b0}}, obs_vec()}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("after_reset", {{(32-VW){1'b0}}, obs_vec()},
             {{(32-VW){1'b0}}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});

    // Directed instructions
    issue(8'b000_011_10, 99);
    issue(8'b001_101_11, 99);
    issue(8'b100_001_01, 99);
    issue(8'b010_110_00, 99);
    issue(8'b010_110_01, 99);
    issue(8'b011_100_10, 99);
    issue(8'b111_010_11, 99);
    issue(8'b101_001_01, 99);
    issue(8'b110_111_10, 99);

    // Asynchronous reset during ROM_RD of a LOAD
    issue(8'b001_010_10, 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_reset", {{(32-VW){1'b0}}, obs_vec()}, 32'd0);
    @(posedge clk); #1;
    check_eq("reset_hold", {{(32-VW){1'b0}}, obs_vec()}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rerelease", {{(32-VW){1'b0}}, obs_vec()},
             {{(32-VW){1'b0}}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    issue(8'b000_001_11, 99);

    // Random instructions with random idle gaps
    for (int i = 0; i < 80; i++) begin
      ins = 8'($urandom_range(0, 255));
      issue(ins, 99);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
